// File: rtl/fetch_pc_unit.sv
// LC-3 program counter and instruction-fetch sequencer.
// Holds the architectural PC, runs MAR/read/IR-latch handshake, and feeds PC+1 back to the PC mux.
module fetch_pc_unit #(
  parameter logic [15:0] RESET_PC = 16'h3000,
  parameter int          TIMEOUT  = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ld_pc,
  input  logic [15:0] pc_next,
  input  logic        fetch_req,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ready,
  output logic [15:0] pc,
  output logic [15:0] pc_plus1,
  output logic [15:0] mar,
  output logic        mem_oe,
  output logic [15:0] ir,
  output logic        fetch_busy,
  output logic        fetch_done,
  output logic        fetch_err
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    READ  = 3'd2,
    LATCH = 3'd3,
    FAULT = 3'd4
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state_reg, state_next;
  logic [15:0] pc_reg, pc_reg_next;
  logic [15:0] mar_reg, mar_reg_next;
  logic [15:0] ir_reg, ir_reg_next;
  logic [7:0]  cnt_reg, cnt_reg_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      pc_reg    <= RESET_PC;
      mar_reg   <= 16'h0000;
      ir_reg    <= 16'h0000;
      cnt_reg   <= 8'd0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_reg_next;
      mar_reg   <= mar_reg_next;
      ir_reg    <= ir_reg_next;
      cnt_reg   <= cnt_reg_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    pc_reg_next  = pc_reg;
    mar_reg_next = mar_reg;
    ir_reg_next  = ir_reg;
    cnt_reg_next = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (ld_pc) pc_reg_next = pc_next;
        // A same-cycle PC load is bypassed straight into MAR.
        if (fetch_req) begin
          mar_reg_next = ld_pc ? pc_next : pc_reg;
          state_next   = ADDR;
        end
      end
      ADDR: begin
        pc_reg_next  = pc_reg + 16'd1;
        cnt_reg_next = 8'd0;
        state_next   = READ;
      end
      READ: begin
        if (mem_ready) begin
          ir_reg_next = mem_rdata;
          state_next  = LATCH;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = FAULT;
        end else begin
          cnt_reg_next = cnt_reg + 8'd1;
        end
      end
      LATCH:   state_next = IDLE;
      FAULT:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign pc         = pc_reg;
  assign pc_plus1   = pc_reg + 16'd1;
  assign mar        = mar_reg;
  assign ir         = ir_reg;
  assign mem_oe     = (state_reg == ADDR) || (state_reg == READ);
  assign fetch_busy = (state_reg != IDLE);
  assign fetch_done = (state_reg == LATCH);
  assign fetch_err  = (state_reg == FAULT);

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Randomized self-checking bench for fetch_pc_unit against a transaction-level fetch model.
module tb_fetch_pc_unit;

  localparam logic [15:0] RESET_PC = 16'h3000;
  localparam int          TIMEOUT  = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        ld_pc;
  logic [15:0] pc_next;
  logic        fetch_req;
  logic [15:0] mem_rdata;
  logic        mem_ready;
  logic [15:0] pc;
  logic [15:0] pc_plus1;
  logic [15:0] mar;
  logic        mem_oe;
  logic [15:0] ir;
  logic        fetch_busy;
  logic        fetch_done;
  logic        fetch_err;

  int n_checks = 0;
  int n_pass   = 0;

  // Architectural view of the unit: just PC and IR between fetches.
  logic [15:0] pc_model;
  logic [15:0] ir_model;

  fetch_pc_unit #(.RESET_PC(RESET_PC), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .ld_pc      (ld_pc),
    .pc_next    (pc_next),
    .fetch_req  (fetch_req),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready),
    .pc         (pc),
    .pc_plus1   (pc_plus1),
    .mar        (mar),
    .mem_oe     (mem_oe),
    .ir         (ir),
    .fetch_busy (fetch_busy),
    .fetch_done (fetch_done),
    .fetch_err  (fetch_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic check_reset_state();
    logic [15:0] exp_p1;
    exp_p1 = RESET_PC + 16'd1;
    check("rst_pc", pc, RESET_PC);
    check("rst_pc_plus1", pc_plus1, exp_p1);
    check("rst_mar", mar, 16'h0000);
    check("rst_ir", ir, 16'h0000);
    check("rst_oe", mem_oe, 1'b0);
    check("rst_busy", fetch_busy, 1'b0);
    check("rst_done", fetch_done, 1'b0);
    check("rst_err", fetch_err, 1'b0);
  endtask

  // Load a PC value in IDLE without fetching.
  task automatic load_pc(input logic [15:0] v);
    logic [15:0] exp_p1;
    @(negedge clk);
    ld_pc = 1'b1; pc_next = v; fetch_req = 1'b0;
    @(posedge clk); #1;
    ld_pc = 1'b0;
    @(negedge clk);
    pc_model = v;
    exp_p1 = v + 16'd1;
    check("load_pc", pc, pc_model);
    check("load_pc_plus1", pc_plus1, exp_p1);
    check("load_busy", fetch_busy, 1'b0);
    $display("load pc=%h", v);
  endtask

  // One fetch; delay = READ cycles before mem_ready, delay >= TIMEOUT means never ready.
  task automatic do_fetch(input logic ld, input logic [15:0] pn, input int delay);
    logic [15:0] base, inc, exp_ir;
    int          oe_cnt;
    bit          got_ready;
    base   = ld ? pn : pc_model;
    inc    = base + 16'd1;
    exp_ir = ir_model;
    @(negedge clk);
    check("idle_busy", fetch_busy, 1'b0);
    fetch_req = 1'b1; ld_pc = ld; pc_next = pn; mem_ready = 1'b0;
    @(posedge clk); #1;
    fetch_req = 1'b0; ld_pc = 1'b0;
    @(negedge clk);
    check("addr_mar", mar, base);
    check("addr_pc", pc, base);
    check("addr_oe", mem_oe, 1'b1);
    oe_cnt = mem_oe ? 1 : 0;
    got_ready = 1'b0;
    for (int j = 0; j < TIMEOUT; j++) begin
      @(posedge clk); #1;
      // ld_pc during READ must be ignored.
      ld_pc     = 1'b1;
      pc_next   = 16'($urandom);
      mem_ready = (j == delay);
      mem_rdata = 16'($urandom);
      if (j == delay) exp_ir = mem_rdata;
      @(negedge clk);
      if (mem_oe) oe_cnt++;
      check("read_done", fetch_done, 1'b0);
      check("read_err", fetch_err, 1'b0);
      check("read_pc", pc, inc);
      if (j == delay) begin
        got_ready = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    ld_pc = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    if (got_ready) begin
      check("done_pulse", fetch_done, 1'b1);
      check("done_no_err", fetch_err, 1'b0);
      check("oe_cycles", oe_cnt, delay + 2);
    end else begin
      check("err_pulse", fetch_err, 1'b1);
      check("err_no_done", fetch_done, 1'b0);
      check("oe_cycles", oe_cnt, TIMEOUT + 1);
    end
    check("end_oe", mem_oe, 1'b0);
    check("end_ir", ir, exp_ir);
    check("end_pc", pc, inc);
    @(posedge clk); #1;
    @(negedge clk);
    check("idle_done", fetch_done, 1'b0);
    check("idle_err", fetch_err, 1'b0);
    check("idle_busy_after", fetch_busy, 1'b0);
    check("idle_pc", pc, inc);
    pc_model = inc;
    ir_model = exp_ir;
    $display("fetch ld=%0b addr=%h delay=%0d result=%s ir=%h pc=%h",
             ld, base, delay, got_ready ? "done" : "err", ir, pc);
  endtask

  task automatic reset_mid_read();
    bit seen;
    @(negedge clk);
    fetch_req = 1'b1; ld_pc = 1'b0; mem_ready = 1'b0;
    @(posedge clk); #1;
    fetch_req = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    check("pre_rst_oe", mem_oe, 1'b1);
    rst = 1'b1;
    #1;
    check("mid_rst_oe", mem_oe, 1'b0);
    check("mid_rst_busy", fetch_busy, 1'b0);
    check("mid_rst_pc", pc, RESET_PC);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (fetch_done || fetch_err || fetch_busy) seen = 1'b1;
    end
    check("post_rst_quiet", seen, 1'b0);
    pc_model = RESET_PC;
    ir_model = 16'h0000;
    $display("reset during READ, pc=%h", pc);
  endtask

  initial begin
    rst = 1'b1; ld_pc = 1'b0; pc_next = 16'h0000; fetch_req = 1'b0;
    mem_rdata = 16'h0000; mem_ready = 1'b0;
    pc_model = RESET_PC; ir_model = 16'h0000;
    #1;
    check_reset_state();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_reset_state();

    do_fetch(1'b0, 16'h0000, 0);
    do_fetch(1'b0, 16'h0000, 3);
    do_fetch(1'b0, 16'h0000, TIMEOUT + 5);
    do_fetch(1'b0, 16'h0000, TIMEOUT - 1);
    do_fetch(1'b1, 16'h4000, 1);
    load_pc(16'hFFFF);
    do_fetch(1'b0, 16'h0000, 0);

    for (int t = 0; t < 24; t++) begin
      logic        ld;
      logic [15:0] pn;
      int          dly;
      ld  = 1'($urandom_range(0, 1));
      pn  = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      dly = $urandom_range(0, TIMEOUT + 2);
      do_fetch(ld, pn, dly);
    end

    reset_mid_read();
    check_reset_state();
    do_fetch(1'b0, 16'h0000, 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Program-counter register and instruction-fetch sequencer for the LC-3 datapath.
- Sits directly downstream of the PC-select multiplexer: consumes the selected next-PC value and holds the architectural PC.
- Runs the fetch handshake to memory (MAR load, read, IR latch).
- Returns PC+1 to the multiplexer's increment input.

Parameters:
- RESET_PC, 16'h3000, PC value loaded on reset.
- TIMEOUT, 15, maximum READ-state cycles without mem_ready before the fetch aborts (legal range 1..255).

Ports:
- Clk  input  1  system clock, rising-edge.
- Reset  input  1  asynchronous, active-high reset.
- ld_pc  input  1  load pc_next into PC (honoured only in IDLE).
- pc_next  input  16  next-PC value from the PC-select multiplexer.
- fetch_req  input  1  request an instruction fetch (level, sampled in IDLE).
- mem_rdata  input  16  memory read data.
- mem_ready  input  1  memory read data valid this cycle.
- pc  output  16  current PC.
- pc_plus1  output  16  combinational pc + 1, mod 2^16.
- mar  output  16  memory address register.
- mem_oe  output  1  memory read enable.
- ir  output  16  instruction register.
- fetch_busy  output  1  high whenever state != IDLE.
- fetch_done  output  1  one-cycle pulse: IR holds the new instruction.
- fetch_err  output  1  one-cycle pulse: fetch timed out; IR unchanged.

Behaviour:
- Reset, asynchronous and immediate in any state:
  - pc=RESET_PC, mar=0, ir=0, state=IDLE, timeout counter=0.
  - mem_oe, fetch_busy, fetch_done and fetch_err all 0.
  - pc_plus1 = RESET_PC+1.
- States: IDLE, ADDR, READ, LATCH, FAULT. All outputs except pc_plus1 are registered or decoded from state.
- IDLE:
  - ld_pc=1: pc<=pc_next.
  - fetch_req=1: mar<=(ld_pc ? pc_next : pc), then go to ADDR. With both asserted, the new PC is bypassed into MAR.
  - fetch_req=0: stay in IDLE.
- ADDR:
  - mem_oe=1, pc<=pc+1, counter<=0, then go to READ.
  - mem_ready is ignored in this state.
- READ:
  - mem_oe=1.
  - mem_ready=1: ir<=mem_rdata, go to LATCH.
  - Otherwise, if counter==TIMEOUT-1: go to FAULT.
  - Otherwise: counter<=counter+1.
- LATCH: fetch_done=1, mem_oe=0, then go to IDLE.
- FAULT:
  - fetch_err=1, then go to IDLE.
  - ir holds its previous value. pc stays incremented (no rollback).
- fetch_busy=1 in ADDR, READ, LATCH and FAULT.
- ld_pc outside IDLE is ignored: no queueing and no effect.
- Latency: fetch_req accepted at edge N gives fetch_done high in cycle N+2+k, where k = number of READ cycles with mem_ready=0.
- Minimum fetch period is 4 cycles. fetch_req held high gives back-to-back fetches with one IDLE cycle between them.
- Wrap-around: pc=16'hFFFF increments to 16'h0000; pc_plus1 of 16'hFFFF is 16'h0000.
- Reset during READ: mem_oe drops asynchronously; no fetch_done or fetch_err is produced.

Test Plan:
- Reset, then fetch_req=1 for one cycle with mem_ready=1 throughout:
  - pc=3000 at reset.
  - mar=3000 in ADDR.
  - ir=mem_rdata(0x1234) and fetch_done in cycle N+2.
  - pc=3001, pc_plus1=3002.
- fetch_req with mem_ready held low for 3 READ cycles, then high:
  - mem_oe high for 4 READ cycles plus 1 ADDR cycle.
  - fetch_done exactly one cycle, in cycle N+5.
- mem_ready never asserted (TIMEOUT=15):
  - FAULT after 15 READ cycles, fetch_err single pulse.
  - ir unchanged, pc incremented, returns to IDLE.
- ld_pc=1, pc_next=0x4000 and fetch_req=1 in the same IDLE cycle:
  - mar=0x4000, after fetch pc=0x4001.
  - ld_pc=1 with pc_next=0x5000 asserted during READ: no effect.
- pc loaded to 0xFFFF, then fetch:
  - pc_plus1=0x0000 before the fetch.
  - pc=0x0000 after ADDR; mar=0xFFFF.
- Reset asserted mid-READ:
  - mem_oe=0 and fetch_busy=0 immediately.
  - pc=3000; no done or err pulse after release.
